// File: rtl/ntt_iter_engine.sv
// Iterative radix-2 DIT NTT engine: bit-reversed load, on-the-fly twiddle table,
// one shared butterfly per cycle for LOGN stages, natural-order streamed output.
module ntt_iter_engine #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int LOGN = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    mod,
    input  logic [W-1:0]    omega,
    input  logic            inv,
    input  logic [W-1:0]    ninv,
    output logic            busy,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [LOGN-1:0] out_idx,
    output logic            done
);

    localparam int HALF = N / 2;
    localparam int JW   = LOGN - 1;
    localparam int SW   = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam logic [SW-1:0]   LAST_STAGE = SW'(LOGN - 1);
    localparam logic [LOGN-1:0] LAST_IDX   = LOGN'(N - 1);
    localparam logic [LOGN-1:0] HALF_IDX   = LOGN'(HALF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_OUT,
        S_DONE
    } state_t;

    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(p % {{W{1'b0}}, m});
    endfunction

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[W-1:0];
    endfunction

    // Wrapping W-bit arithmetic yields the right residue because the result is < m.
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        return (a >= b) ? (a - b) : (a - b + m);
    endfunction

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] n);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) begin
            r[b] = n[LOGN-1-b];
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    mod_q, mod_d;
    logic [W-1:0]    omega_q, omega_d;
    logic            inv_q, inv_d;
    logic [W-1:0]    ninv_q, ninv_d;
    logic [LOGN-1:0] cnt_q, cnt_d;
    logic [JW-1:0]   j_q, j_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [LOGN-1:0] twk_q, twk_d;
    logic [W-1:0]    tw_acc_q, tw_acc_d;
    logic            busy_q, busy_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;

    logic [W-1:0] a_q [N];
    logic [W-1:0] tw_q [HALF];

    logic            load_we;
    logic            bf_we;
    logic            tw_we;
    logic [JW-1:0]   tw_waddr;
    logic [W-1:0]    tw_wdata;

    logic [LOGN-1:0] jx, h, jm, i0, i1;
    logic [JW-1:0]   tw_idx;
    logic [W-1:0]    bf_t, bf_x, bf_y;
    logic [W-1:0]    out_scaled;

    // Butterfly operand addressing for the current (stage, j) pair.
    always_comb begin
        jx     = {1'b0, j_q};
        h      = LOGN'(1) << stage_q;
        jm     = jx & (h - LOGN'(1));
        i0     = ((jx >> stage_q) << (int'(stage_q) + 1)) + jm;
        i1     = i0 + h;
        tw_idx = JW'(jm << (LOGN - 1 - int'(stage_q)));
        bf_t   = mul_mod(tw_q[tw_idx], a_q[i1], mod_q);
        bf_x   = add_mod(a_q[i0], bf_t, mod_q);
        bf_y   = sub_mod(a_q[i0], bf_t, mod_q);
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        mod_d       = mod_q;
        omega_d     = omega_q;
        inv_d       = inv_q;
        ninv_d      = ninv_q;
        cnt_d       = cnt_q;
        j_d         = j_q;
        stage_d     = stage_q;
        twk_d       = twk_q;
        tw_acc_d    = tw_acc_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        load_we     = 1'b0;
        bf_we       = 1'b0;
        tw_we       = 1'b0;
        tw_waddr    = '0;
        tw_wdata    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    mod_d      = mod;
                    omega_d    = omega;
                    inv_d      = inv;
                    ninv_d     = ninv;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                    tw_we      = 1'b1;
                    tw_waddr   = '0;
                    tw_wdata   = W'(1);
                    tw_acc_d   = omega;
                    twk_d      = LOGN'(1);
                end
            end
            S_LOAD: begin
                // Twiddle powers advance every cycle regardless of input gaps.
                if (twk_q < HALF_IDX) begin
                    tw_we    = 1'b1;
                    tw_waddr = JW'(twk_q);
                    tw_wdata = tw_acc_q;
                    tw_acc_d = mul_mod(tw_acc_q, omega_q, mod_q);
                    twk_d    = twk_q + LOGN'(1);
                end
                if (in_valid) begin
                    load_we = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d    = S_COMPUTE;
                        cnt_d      = '0;
                        in_ready_d = 1'b0;
                        j_d        = '0;
                        stage_d    = '0;
                    end else begin
                        cnt_d = cnt_q + LOGN'(1);
                    end
                end
            end
            S_COMPUTE: begin
                bf_we = 1'b1;
                if (j_q == '1) begin
                    j_d = '0;
                    if (stage_q == LAST_STAGE) begin
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + LOGN'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mod_q       <= '0;
            omega_q     <= '0;
            inv_q       <= 1'b0;
            ninv_q      <= '0;
            cnt_q       <= '0;
            j_q         <= '0;
            stage_q     <= '0;
            twk_q       <= '0;
            tw_acc_q    <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mod_q       <= mod_d;
            omega_q     <= omega_d;
            inv_q       <= inv_d;
            ninv_q      <= ninv_d;
            cnt_q       <= cnt_d;
            j_q         <= j_d;
            stage_q     <= stage_d;
            twk_q       <= twk_d;
            tw_acc_q    <= tw_acc_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // NOTE: storage arrays carry no reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (load_we) begin
            a_q[bitrev(cnt_q)] <= in_data;
        end
        if (bf_we) begin
            a_q[i0] <= bf_x;
            a_q[i1] <= bf_y;
        end
        if (tw_we) begin
            tw_q[tw_waddr] <= tw_wdata;
        end
    end

    always_comb begin
        out_scaled = inv_q ? mul_mod(a_q[cnt_q], ninv_q, mod_q) : a_q[cnt_q];
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign out_data  = out_valid_q ? out_scaled : '0;
    assign out_idx   = out_valid_q ? cnt_q : '0;

endmodule

// File: tb/tb_ntt_iter_engine.sv
// Scoreboard bench for ntt_iter_engine (N=8, W=8): directed vectors with hand-computed results.
module tb_ntt_iter_engine;

    localparam int N    = 8;
    localparam int W    = 8;
    localparam int LOGN = 3;

    typedef struct {
        logic [LOGN-1:0] idx;
        logic [W-1:0]    data;
    } exp_t;

    typedef logic [W-1:0] vec_t [N];

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W-1:0]    mod;
    logic [W-1:0]    omega;
    logic            inv;
    logic [W-1:0]    ninv;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [LOGN-1:0] out_idx;
    logic            done;

    exp_t sb [$];
    int   tests     = 0;
    int   fails     = 0;
    int   done_cnt  = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    bit   lat_armed = 1'b0;
    bit   rdy_rand  = 1'b0;
    bit   hold_valid = 1'b0;
    logic [LOGN-1:0] hold_idx;
    logic [W-1:0]    hold_data;

    ntt_iter_engine #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mod       (mod),
        .omega     (omega),
        .inv       (inv),
        .ninv      (ninv),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every accepted beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (out_valid) begin
                if (lat_armed) begin
                    check("latency", cyc - start_cyc, 21);
                    lat_armed = 1'b0;
                end
                if (hold_valid) begin
                    check("stall_idx_stable", int'(out_idx), int'(hold_idx));
                    check("stall_data_stable", int'(out_data), int'(hold_data));
                end
                if (out_ready) begin
                    hold_valid = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("out_idx", int'(out_idx), int'(e.idx));
                        check("out_data", int'(out_data), int'(e.data));
                    end
                end else begin
                    hold_valid = 1'b1;
                    hold_idx   = out_idx;
                    hold_data  = out_data;
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_beat(input logic [W-1:0] d);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic kick(input logic [W-1:0] q, input logic [W-1:0] om, input logic iv,
                        input logic [W-1:0] ni, input vec_t din, input bit gaps);
        mod   = q;
        omega = om;
        inv   = iv;
        ninv  = ni;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble the configuration inputs: the engine must use its captured copy.
        mod   = 8'd251;
        omega = 8'd3;
        inv   = ~iv;
        ninv  = 8'd1;
        check("busy_after_start", int'(busy), 1);
        for (int n = 0; n < N; n++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(din[n]);
        end
    endtask

    task automatic run(input logic [W-1:0] q, input logic [W-1:0] om, input logic iv,
                       input logic [W-1:0] ni, input vec_t din, input vec_t dexp,
                       input bit gaps, input bit lat, input bit poke);
        int d0;
        int t;
        for (int k = 0; k < N; k++) begin
            exp_t e;
            e.idx  = LOGN'(k);
            e.data = dexp[k];
            sb.push_back(e);
        end
        d0 = done_cnt;
        lat_armed = lat;
        kick(q, om, iv, ni, din, gaps);
        if (poke) begin
            start = 1'b1;
            omega = 8'd5;
            @(posedge clk);
            #1;
            start = 1'b0;
            check("busy_start_ignored", int'(busy), 1);
            check("in_ready_start_ignored", int'(in_ready), 0);
        end
        t = 0;
        while (!done && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!done) begin
            check("done_timeout", 0, 1);
        end else if (poke) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check("start_in_done_busy", int'(busy), 0);
            check("start_in_done_ready", int'(in_ready), 0);
        end
        lat_armed = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("done_once", done_cnt - d0, 1);
        check("scoreboard_empty", sb.size(), 0);
        sb.delete();
    endtask

    vec_t v_imp, v_x1, v_e2, v_16, v_1, v_all1, v_e16, v_e1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        v_imp  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        v_all1 = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        v_x1   = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        v_e2   = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15, 8'd13, 8'd9};
        v_16   = '{8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16};
        v_e16  = '{8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        v_1    = v_all1;
        v_e1   = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

        rst      = 1'b1;
        start    = 1'b0;
        mod      = '0;
        omega    = '0;
        inv      = 1'b0;
        ninv     = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_done", int'(done), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_idx", int'(out_idx), 0);

        // Impulse, shifted impulse, inverse round trip, wrap at q-1, all-ones.
        run(8'd17, 8'd2, 1'b0, 8'd15, v_imp, v_all1, 1'b0, 1'b1, 1'b0);
        run(8'd17, 8'd2, 1'b0, 8'd15, v_x1, v_e2, 1'b0, 1'b0, 1'b0);
        run(8'd17, 8'd9, 1'b1, 8'd15, v_e2, v_x1, 1'b0, 1'b0, 1'b0);
        run(8'd17, 8'd2, 1'b0, 8'd15, v_16, v_e16, 1'b0, 1'b0, 1'b0);
        run(8'd17, 8'd2, 1'b0, 8'd15, v_1, v_e1, 1'b0, 1'b0, 1'b0);

        // Input gaps, output back-pressure, start pulses while busy and in DONE.
        rdy_rand = 1'b1;
        run(8'd17, 8'd2, 1'b0, 8'd15, v_imp, v_all1, 1'b1, 1'b0, 1'b1);
        run(8'd17, 8'd2, 1'b0, 8'd15, v_x1, v_e2, 1'b1, 1'b0, 1'b1);
        run(8'd17, 8'd9, 1'b1, 8'd15, v_e2, v_x1, 1'b1, 1'b0, 1'b0);
        rdy_rand = 1'b0;

        // Reset in the middle of COMPUTE, then a fresh run.
        kick(8'd17, 8'd2, 1'b0, 8'd15, v_x1, 1'b0);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run(8'd17, 8'd2, 1'b0, 8'd15, v_x1, v_e2, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
